// File: rtl/uart_receiver.sv
// UART receiver: recovers DBIT-data-bit frames from a 16x-oversampled serial
// line. Each completed frame updates o_data and pulses o_rx_done for one
// cycle. o_frame_error pulses alongside it when the stop bit is sampled low.
module uart_receiver #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_rx,
   input  logic            i_tickSignal,
   output logic [DBIT-1:0] o_data,
   output logic            o_rx_done,
   output logic            o_frame_error
);

   // The tick counter must reach SB_TICK-1 in STOP, so it widens for long stop bits.
   localparam int TW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
   logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DBIT-1:0] shreg_q, shreg_d;
   logic [DBIT-1:0] data_q, data_d;
   logic            done_q, done_d;
   logic            ferr_q, ferr_d;
   logic            sync1_q, rx_s_q;

   // Two-flop synchronizer for the asynchronous line. It resets to idle-high.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         sync1_q <= i_rx;
         rx_s_q  <= sync1_q;
      end
   end

   // State, counters, shift register and registered outputs.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         data_q     <= data_d;
         done_q     <= done_d;
         ferr_q     <= ferr_d;
      end
   end

   // Next-state logic. The counters move only on baud ticks, so the FSM
   // freezes whenever the baud generator stalls.
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      data_d     = data_q;
      done_d     = 1'b0;
      ferr_d     = 1'b0;
      case (state_q)
         IDLE: begin
            // Level-based start detection; no tick needed to leave IDLE.
            if (!rx_s_q) begin
               state_d    = START;
               tick_cnt_d = '0;
            end
         end
         START: begin
            if (i_tickSignal) begin
               if (tick_cnt_q == TW'(7)) begin
                  // Mid-start-bit: a line that is high again was a glitch.
                  if (!rx_s_q) begin
                     state_d    = DATA;
                     tick_cnt_d = '0;
                     bit_cnt_d  = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (i_tickSignal) begin
               if (tick_cnt_q == TW'(15)) begin
                  tick_cnt_d = '0;
                  shreg_d    = {rx_s_q, shreg_q[DBIT-1:1]};
                  if (bit_cnt_q == BW'(DBIT - 1)) state_d = STOP;
                  else                            bit_cnt_d = bit_cnt_q + 1'b1;
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (i_tickSignal) begin
               if (tick_cnt_q == TW'(SB_TICK - 1)) begin
                  // Leave at mid-stop so an immediately following start bit is caught.
                  state_d = IDLE;
                  data_d  = shreg_q;
                  done_d  = 1'b1;
                  ferr_d  = ~rx_s_q;
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_data        = data_q;
   assign o_rx_done     = done_q;
   assign o_frame_error = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: 8N1 frames at 16 ticks/bit, one tick every 4 clocks.
module tb_uart_receiver;

   localparam int BITCLK = 64;

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_rx = 1'b1;
   logic       i_tickSignal = 1'b0;
   logic [7:0] o_data;
   logic       o_rx_done;
   logic       o_frame_error;

   int   n_chk = 0;
   int   n_pass = 0;
   int   done_cnt = 0;
   int   fe_cnt = 0;
   int   fe_orphan = 0;
   logic [7:0] cap_data [$];
   logic       cap_fe [$];
   bit   tick_en = 1'b1;
   int   div = 0;
   int   base;

   uart_receiver #(.DBIT(8), .SB_TICK(16)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_rx(i_rx), .i_tickSignal(i_tickSignal),
      .o_data(o_data), .o_rx_done(o_rx_done), .o_frame_error(o_frame_error)
   );

   always #5 i_clk = ~i_clk;

   // Baud tick generator; the divider phase freezes while ticks are disabled.
   always @(negedge i_clk) begin
      if (tick_en) begin
         div = (div + 1) % 4;
         i_tickSignal = (div == 0);
      end else begin
         i_tickSignal = 1'b0;
      end
   end

   // Output monitor: records each done pulse and any stray frame-error pulse.
   always @(negedge i_clk) begin
      if (o_rx_done) begin
         done_cnt++;
         cap_data.push_back(o_data);
         cap_fe.push_back(o_frame_error);
         if (o_frame_error) fe_cnt++;
      end else if (o_frame_error) begin
         fe_orphan++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   // One frame. stop_clks shortens a low stop bit so the receiver's re-entry
   // into START sees a high line at mid-bit; stall_bit >= 0 pauses ticks for
   // 200 clocks early in that data bit, stretching the bit by the same amount.
   task automatic send(input logic [7:0] d, input logic stop_val,
                       input int stop_clks, input int stall_bit);
      i_rx = 1'b0;
      hold(BITCLK);
      for (int i = 0; i < 8; i++) begin
         i_rx = d[i];
         if (i == stall_bit) begin
            hold(8);
            tick_en = 1'b0;
            hold(200);
            tick_en = 1'b1;
            hold(BITCLK - 8);
         end else begin
            hold(BITCLK);
         end
      end
      i_rx = stop_val;
      hold(stop_clks);
      i_rx = 1'b1;
      if (stop_clks < BITCLK) hold(BITCLK - stop_clks);
   endtask

   initial begin
      hold(5);
      chk("reset_data", {24'd0, o_data}, 32'h00);
      chk("reset_done", {31'd0, o_rx_done}, 32'd0);
      chk("reset_ferr", {31'd0, o_frame_error}, 32'd0);
      i_reset = 1'b0;
      hold(20);

      // Single frame 0xA5.
      base = done_cnt;
      send(8'hA5, 1'b1, BITCLK, -1);
      hold(40);
      chk("a5_pulses", done_cnt - base, 32'd1);
      chk("a5_data", {24'd0, cap_data[cap_data.size()-1]}, 32'hA5);
      chk("a5_ferr", {31'd0, cap_fe[cap_fe.size()-1]}, 32'd0);
      hold(100);
      chk("a5_hold", {24'd0, o_data}, 32'hA5);

      // Back-to-back frames with no idle gap.
      base = done_cnt;
      send(8'h00, 1'b1, BITCLK, -1);
      send(8'hFF, 1'b1, BITCLK, -1);
      hold(40);
      chk("b2b_pulses", done_cnt - base, 32'd2);
      chk("b2b_first", {24'd0, cap_data[base]}, 32'h00);
      chk("b2b_second", {24'd0, cap_data[base+1]}, 32'hFF);
      chk("b2b_ferr", fe_cnt, 32'd0);

      // Low glitch of 4 ticks on the idle line.
      base = done_cnt;
      i_rx = 1'b0;
      hold(16);
      i_rx = 1'b1;
      hold(300);
      chk("glitch_pulses", done_cnt - base, 32'd0);
      chk("glitch_data", {24'd0, o_data}, 32'hFF);
      send(8'h55, 1'b1, BITCLK, -1);
      hold(40);
      chk("post_glitch_pulses", done_cnt - base, 32'd1);
      chk("post_glitch_data", {24'd0, o_data}, 32'h55);

      // Framing error: stop bit sampled low.
      base = done_cnt;
      send(8'h3C, 1'b0, 48, -1);
      hold(300);
      chk("ferr_pulses", done_cnt - base, 32'd1);
      chk("ferr_data", {24'd0, cap_data[base]}, 32'h3C);
      chk("ferr_flag", {31'd0, cap_fe[base]}, 32'd1);

      // Reset during bit 4 of 0x5A, then a clean 0x81.
      base = done_cnt;
      i_rx = 1'b0;
      hold(BITCLK);
      for (int i = 0; i < 4; i++) begin
         i_rx = (8'h5A >> i) & 1;
         hold(BITCLK);
      end
      i_rx = 1'b0;
      hold(20);
      i_reset = 1'b1;
      i_rx = 1'b1;
      hold(4);
      i_reset = 1'b0;
      hold(2);
      chk("abort_data", {24'd0, o_data}, 32'h00);
      hold(700);
      chk("abort_pulses", done_cnt - base, 32'd0);
      send(8'h81, 1'b1, BITCLK, -1);
      hold(40);
      chk("after_reset_pulses", done_cnt - base, 32'd1);
      chk("after_reset_data", {24'd0, o_data}, 32'h81);

      // Tick stall in the middle of the data bits.
      base = done_cnt;
      send(8'hC3, 1'b1, BITCLK, 3);
      hold(40);
      chk("stall_pulses", done_cnt - base, 32'd1);
      chk("stall_data", {24'd0, o_data}, 32'hC3);
      chk("stall_ferr", {31'd0, cap_fe[base]}, 32'd0);

      chk("orphan_ferr", fe_orphan, 32'd0);
      chk("total_ferr", fe_cnt, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART receive side of the serial link, paired with the existing 16x-oversampled transmitter.
- Takes the asynchronous serial line and the shared 16x baud tick from the baud generator.
- Recovers 8N1 frames (parameterisable data width and stop length) and presents each received word with a one-cycle done pulse.
- Downstream consumer is the interface/ALU control logic.

Parameters:
DBIT, 8, number of data bits per frame, LSB first
SB_TICK, 16, tick count spanning the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous, active-high reset
i_rx  input  1  serial line, idle high, asynchronous to i_clk
i_tickSignal  input  1  one-cycle pulse at 16x baud rate from baud generator
o_data  output  DBIT  last received word, held until next frame completes
o_rx_done  output  1  one-cycle pulse, frame complete, o_data valid
o_frame_error  output  1  one-cycle pulse coincident with o_rx_done when stop bit sampled low

Behaviour:
- Reset (async, i_reset=1):
  - state=IDLE; tick and bit counters=0; shift register=0.
  - o_data=0, o_rx_done=0, o_frame_error=0.
  - Both synchronizer flops=1 (line idle).
- Input sync: i_rx passes through a 2-flop synchronizer; all FSM decisions use the synchronized value rx_s.
  - rx_s lags i_rx by 2 cycles.
- Counters: tick counter 4 bits for START/DATA; widened to ceil(log2(SB_TICK)) bits if SB_TICK>16. Bit counter ceil(log2(DBIT)) bits.
- Counters advance only on cycles with i_tickSignal=1. Without ticks the FSM holds state indefinitely.
- FSM:
  - IDLE: if rx_s==0 -> START, tick counter cleared. Does not need a tick to leave IDLE.
  - START: on tick, if counter==7:
    - rx_s==0 -> DATA, tick and bit counters cleared (this is mid-start-bit alignment).
    - rx_s==1 -> IDLE (glitch/false start, no outputs asserted).
    - Otherwise counter+1.
  - DATA: on tick, if counter==15:
    - counter cleared; shift register <= {rx_s, shreg[DBIT-1:1]}, so LSB arrives first.
    - If bit counter==DBIT-1 -> STOP; else bit counter+1.
    - Otherwise counter+1.
  - STOP: on tick, if counter==SB_TICK-1:
    - -> IDLE.
    - o_data <= shift register; o_rx_done pulses 1 next cycle; o_frame_error <= ~rx_s for that same cycle.
    - Otherwise counter+1.
  - Illegal state -> IDLE.
- Outputs registered. o_rx_done and o_frame_error are high for exactly one i_clk cycle, the cycle after the final stop tick.
- o_data updates in that same cycle and is held until the next completed frame.
- A frame with a framing error still updates o_data and pulses o_rx_done.
- FSM returns to IDLE at mid-stop-bit, so a start bit immediately following the stop bit is captured (back-to-back frames).
- Line held low after a framing error: IDLE re-enters START immediately. A break produces repeated frames of 0x00 with framing error, which is accepted behaviour.
- Reset mid-frame aborts it: no done pulse, o_data cleared.
- Tick and edge in the same cycle: no special handling. Edge detection in IDLE is level-based on rx_s.

Test Plan:
- Send 0xA5 (8N1, 16 ticks/bit, tick every 4 clk) -> single o_rx_done pulse with o_data=8'hA5, o_frame_error=0; o_data holds 0xA5 afterwards.
- Back-to-back 0x00 then 0xFF, no idle gap -> two done pulses, o_data=0x00 then 0xFF, no frame errors.
- Low glitch on idle line lasting 4 ticks -> FSM returns to IDLE at tick 7, no o_rx_done, o_data unchanged.
- Frame 0x3C with stop bit driven low -> o_rx_done=1 and o_frame_error=1 in the same cycle, o_data=0x3C.
- Assert i_reset during bit 4 of 0x5A, release, then send 0x81 -> no pulse for the aborted frame, o_data=0 after reset, then o_data=0x81 with one done pulse.
- Stop i_tickSignal mid-data for 200 clk, then resume -> frame completes correctly (0xC3), FSM state unchanged during the stall.
